// File: rtl/bcd_disp_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display path.
// Glyphs are stored active-high; seg[0]=a ... seg[6]=g.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    // 0-9 decimal, 10-15 hex A b C d E F
    localparam seg_t SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD/hex nibble to active-high 7-segment glyph.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  bcd_t digit,
    output seg_t glyph
);

    assign glyph = SEG_LUT[digit];

endmodule

// File: rtl/bcd_7seg_scan.sv
// Double-buffered BCD word receiver driving a time-multiplexed 7-segment display
// with leading-zero blanking, per-digit decimal points and a global blank.
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bcd_valid,
    output logic                    bcd_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]        div_cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] pend_data_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic                    pend_full_reg;
    logic [4*NUM_DIGITS-1:0] disp_data_reg;
    logic [NUM_DIGITS-1:0]   disp_dp_reg;
    seg_t                    seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;

    logic tc;
    logic frame_end;
    logic accept;

    assign tc        = (div_cnt_reg == DIV_LAST);
    assign frame_end = tc && (idx_reg == IDX_LAST);
    assign accept    = bcd_valid && !pend_full_reg;
    assign bcd_ready = !pend_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            div_cnt_reg <= tc ? '0 : div_cnt_reg + 1'b1;
            if (tc) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // A word only reaches the display at a frame boundary, so a frame never mixes words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_reg <= '0;
            pend_dp_reg   <= '0;
            pend_full_reg <= 1'b0;
            disp_data_reg <= '0;
            disp_dp_reg   <= '0;
        end else if (accept) begin
            pend_data_reg <= bcd_data;
            pend_dp_reg   <= dp_mask;
            pend_full_reg <= 1'b1;
        end else if (pend_full_reg && frame_end) begin
            disp_data_reg <= pend_data_reg;
            disp_dp_reg   <= pend_dp_reg;
            pend_full_reg <= 1'b0;
        end
    end

    bcd_t digits [NUM_DIGITS];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digits[gi] = disp_data_reg[4*gi +: 4];
    end

    // lz_mask[i] set when digit i and every more significant digit are zero
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (digits[i] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    bcd_t                  digit_cur;
    seg_t                  glyph;
    logic                  seg_off_now;
    logic [NUM_DIGITS-1:0] an_onehot;

    assign digit_cur   = digits[idx_reg];
    assign seg_off_now = blank || ((LZ_BLANK != 0) && lz_mask[idx_reg]);

    always_comb begin
        an_onehot          = '0;
        an_onehot[idx_reg] = 1'b1;
    end

    seg7_decode u_decode (
        .digit (digit_cur),
        .glyph (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= DP_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_off_now ? SEG_OFF : (glyph ^ SEG_OFF);
            dp_reg  <= (disp_dp_reg[idx_reg] && !blank) ^ DP_OFF;
            an_reg  <= an_onehot ^ AN_OFF;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed self-checking bench for bcd_7seg_scan (4 digits, 4 clocks per digit,
// active-low segments and anodes).
module tb_bcd_7seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [15:0] bcd_data = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int vectors = 0;
    int miscompares = 0;

    logic        hold_chk = 1'b0;
    logic [15:0] prev_data = 16'h0000;

    always #5 clk = ~clk;

    bcd_7seg_scan #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .LZ_BLANK       (1),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .bcd_data  (bcd_data),
        .dp_mask   (dp_mask),
        .blank     (blank),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    // Producer rule: an offered but not yet accepted word must stay put.
    always @(posedge clk) begin
        if (rst_n && hold_chk && !(bcd_valid && bcd_data == prev_data))
            $error("producer changed word while stalled");
        hold_chk  <= rst_n && bcd_valid && !bcd_ready;
        prev_data <= bcd_data;
    end

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (k / 4));
    endfunction

    task automatic send_word(input logic [15:0] w, input logic [3:0] m);
        int n;
        n = 0;
        while (bcd_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL send_timeout ready=%b required=1", bcd_ready);
        end
        $display("send word=%h dp_mask=%b", w, m);
        bcd_valid = 1'b1;
        bcd_data  = w;
        dp_mask   = m;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bcd_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL ready_timeout ready=%b required=1", bcd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || bcd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold seg=%h an=%b dp=%b ready=%b required seg=7f an=1111 dp=1 ready=1",
                     seg, an, dp, bcd_ready);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [6:0] es;
            @(negedge clk);
            es = (k < 4) ? 7'h40 : 7'h7F;
            vectors++;
            if (an !== exp_an(k) || seg !== es || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_frame k=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=1",
                         k, an, seg, dp, exp_an(k), es);
            end
        end
    endtask

    task automatic test_digits();
        int n;
        logic [6:0] e [4];
        e = '{7'h19, 7'h30, 7'h24, 7'h79};
        send_word(16'h1234, 4'b0000);
        vectors++;
        if (bcd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_drop ready=%b required=0", bcd_ready);
        end
        wait_ready(n);
        vectors++;
        if (n != 15) begin
            miscompares++;
            $display("FAIL ready_low_cycles got=%0d required=15", n);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an(k) || seg !== e[k/4] || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_1234 k=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=1",
                         k, an, seg, dp, exp_an(k), e[k/4]);
            end
        end
    endtask

    task automatic test_lz_blank();
        int n;
        logic [15:0] words [3];
        logic [6:0]  e [3][4];
        words = '{16'h0007, 16'h0000, 16'h0070};
        e[0] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        e[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        e[2] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
        for (int w = 0; w < 3; w++) begin
            send_word(words[w], 4'b0000);
            wait_ready(n);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                vectors++;
                if (an !== exp_an(k) || seg !== e[w][k/4] || dp !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lz_frame word=%h k=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=1",
                             words[w], k, an, seg, dp, exp_an(k), e[w][k/4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        $display("send word=1111 then word=2222 with valid held");
        bcd_valid = 1'b1;
        bcd_data  = 16'h1111;
        dp_mask   = 4'b0000;
        @(negedge clk);
        vectors++;
        if (bcd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_accept ready=%b required=0", bcd_ready);
        end
        bcd_data = 16'h2222;
        wait_ready(n);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                vectors++;
                if (bcd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_second_accept ready=%b required=0", bcd_ready);
                end
                bcd_valid = 1'b0;
            end
            vectors++;
            if (an !== exp_an(k) || seg !== 7'h79 || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_1111 k=%0d an=%b seg=%h dp=%b required an=%b seg=79 dp=1",
                         k, an, seg, dp, exp_an(k));
            end
        end
        wait_ready(n);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an(k) || seg !== 7'h24 || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_2222 k=%0d an=%b seg=%h dp=%b required an=%b seg=24 dp=1",
                         k, an, seg, dp, exp_an(k));
            end
        end
    endtask

    task automatic test_dp_blank();
        int n;
        logic [6:0] e [4];
        logic       ed;
        e = '{7'h21, 7'h46, 7'h03, 7'h08};
        send_word(16'hABCD, 4'b0100);
        wait_ready(n);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ed = (k / 4 == 2) ? 1'b0 : 1'b1;
            vectors++;
            if (an !== exp_an(k) || seg !== e[k/4] || dp !== ed) begin
                miscompares++;
                $display("FAIL frame_abcd k=%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         k, an, seg, dp, exp_an(k), e[k/4], ed);
            end
        end
        $display("blank asserted");
        blank = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an(k) || seg !== 7'h7F || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL blank_frame k=%0d an=%b seg=%h dp=%b required an=%b seg=7f dp=1",
                         k, an, seg, dp, exp_an(k));
            end
        end
        blank = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n;
        logic [3:0] prev_an;
        prev_an = an;
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (an === 4'b1110 && prev_an === 4'b0111) break;
            prev_an = an;
        end
        vectors++;
        if (n >= 64) begin
            miscompares++;
            $display("FAIL frame_start_timeout an=%b required=1110", an);
        end
        send_word(16'h5678, 4'b1111);
        n = 0;
        while (an !== 4'b1011 && n < 64) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 64 || bcd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_before_reset an=%b ready=%b required an=1011 ready=0", an, bcd_ready);
        end
        $display("reset asserted mid-frame");
        rst_n = 1'b0;
        #1;
        vectors++;
        if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || bcd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset seg=%h an=%b dp=%b ready=%b required seg=7f an=1111 dp=1 ready=1",
                     seg, an, dp, bcd_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [6:0] es;
            @(negedge clk);
            es = (k < 4) ? 7'h40 : 7'h7F;
            vectors++;
            if (an !== exp_an(k) || seg !== es || dp !== 1'b1 || bcd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset k=%0d an=%b seg=%h dp=%b ready=%b required an=%b seg=%h dp=1 ready=1",
                         k, an, seg, dp, bcd_ready, exp_an(k), es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lz_blank();
        test_back_to_back();
        test_dp_blank();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
